// File: rtl/fft_ctrl_pkg.sv
// Shared types and default geometry for the radix-2^2 FFT sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN
    } seq_state_e;

    localparam int N_DEF  = 32;
    localparam int D1_DEF = N_DEF / 2;
    localparam int D2_DEF = D1_DEF / 2;

    function automatic int drain_len(input int d1);
        return 2 * d1 + 1;
    endfunction

    function automatic int latency(input int d1);
        return 2 * d1 + 1;
    endfunction

    localparam int DRAIN_LEN = drain_len(D1_DEF);
    localparam int LATENCY   = latency(D1_DEF);

endpackage

// File: rtl/fft_en_delay.sv
// 1-bit enable delay line of parameterised depth with synchronous clear.
module fft_en_delay #(
    parameter int DEPTH = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], d};
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Framed sequencer for the 2-lane radix-2^2 FFT: stage rotations, stage-2 control,
// coefficient addressing and output valid, derived from one input-valid stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in flight, all counters and outputs at 0
// ST_FILL  | first half-frame entering stage 1, stage 2 not yet active
// ST_RUN   | steady state, i_valid checked at every half-frame boundary
// ST_DRAIN | input stopped, pipeline flushing until drain count expires
module fft_seq_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int D1 = N / 2,
    parameter int D2 = D1 / 2,
    parameter int AW = $clog2(D1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic          i_clr_err,
    output logic          o_twd1,
    output logic          o_stage2_en,
    output logic          o_ctrl_bfii,
    output logic          o_twd2,
    output logic [AW-1:0] o_coeff_addr,
    output logic          o_enable,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err
);

    localparam int CW  = AW + 1;
    localparam int TW2 = $clog2(D2);
    localparam int DCW = $clog2(drain_len(D1));

    localparam logic [CW-1:0]  C1_HALF_M1 = CW'(D1 - 1);
    localparam logic [CW-1:0]  C1_HALF    = CW'(D1);
    localparam logic [CW-1:0]  C1_LAST    = CW'(2 * D1 - 1);
    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    // Drain window counts from the boundary cycle that detected the stop.
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(drain_len(D1) - 2);
    localparam logic [DCW-1:0] D_ONE      = DCW'(1);

    seq_state_e     state;
    logic [CW-1:0]  c1;
    logic [CW-1:0]  c2;
    logic [CW-1:0]  c3;
    logic [DCW-1:0] drain_cnt;
    logic           stage2_en;
    logic           stage2_nxt;
    logic           pend_drain;
    logic           err;
    logic           err_set;
    logic           enable;
    logic           at_boundary;
    logic           pre_boundary;
    logic           idle;

    always_comb begin
        at_boundary  = (c1 == '0) || (c1 == C1_HALF);
        pre_boundary = (c1 == C1_HALF_M1) || (c1 == C1_LAST);
        stage2_nxt   = 1'b0;
        err_set      = 1'b0;
        case (state)
            ST_FILL: begin
                stage2_nxt = (c1 == C1_HALF_M1);
                err_set    = !i_valid;
            end
            ST_RUN: begin
                stage2_nxt = 1'b1;
                err_set    = !i_valid && !at_boundary;
            end
            ST_DRAIN: begin
                // Stage 2 stops once the last half-frame has passed through it.
                stage2_nxt = stage2_en && !pre_boundary;
                err_set    = i_valid;
            end
            default: begin
                stage2_nxt = 1'b0;
                err_set    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            c1         <= '0;
            c2         <= '0;
            drain_cnt  <= '0;
            stage2_en  <= 1'b0;
            pend_drain <= 1'b0;
            err        <= 1'b0;
        end else begin
            stage2_en <= stage2_nxt;
            c2        <= (stage2_en && stage2_nxt) ? c2 + C_ONE : '0;
            if (err_set) begin
                err <= 1'b1;
            end else if (i_clr_err) begin
                err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    pend_drain <= 1'b0;
                    if (i_valid) begin
                        state <= ST_FILL;
                        c1    <= C_ONE;
                    end
                end
                ST_FILL: begin
                    c1 <= c1 + C_ONE;
                    if (!i_valid) pend_drain <= 1'b1;
                    if (c1 == C1_HALF_M1) state <= ST_RUN;
                end
                ST_RUN: begin
                    c1 <= c1 + C_ONE;
                    if (at_boundary && (!i_valid || pend_drain)) begin
                        state      <= ST_DRAIN;
                        drain_cnt  <= DRAIN_LOAD;
                        pend_drain <= 1'b0;
                    end else if (!i_valid) begin
                        pend_drain <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                        c1    <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - D_ONE;
                        c1        <= c1 + C_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign idle = (state == ST_IDLE);

    fft_en_delay #(
        .DEPTH(latency(D1) - D1)
    ) u_en_delay (
        .clk(clk),
        .rst(rst),
        .clr(idle),
        .d  (stage2_en),
        .q  (enable)
    );

    // Output-side counter tracks c2 as seen through the enable delay line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c3 <= '0;
        end else begin
            c3 <= enable ? c3 + C_ONE : '0;
        end
    end

    assign o_twd1       = (c1 >= C1_HALF);
    assign o_stage2_en  = stage2_en;
    assign o_ctrl_bfii  = c2[AW];
    assign o_twd2       = c2[TW2];
    assign o_coeff_addr = c2[AW-1:0];
    assign o_enable     = enable;
    assign o_frame_done = enable && ((c3 == C1_HALF_M1) || (c3 == C1_LAST));
    assign o_busy       = !idle;
    assign o_err        = err;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: per-cycle output waveforms compared against
// hand-derived high windows for each framing scenario.
module tb_fft_seq_ctrl;
    import fft_ctrl_pkg::*;

    localparam int T0 = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_clr_err = 1'b0;
    logic       o_twd1;
    logic       o_stage2_en;
    logic       o_ctrl_bfii;
    logic       o_twd2;
    logic [3:0] o_coeff_addr;
    logic       o_enable;
    logic       o_frame_done;
    logic       o_busy;
    logic       o_err;

    fft_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_clr_err   (i_clr_err),
        .o_twd1      (o_twd1),
        .o_stage2_en (o_stage2_en),
        .o_ctrl_bfii (o_ctrl_bfii),
        .o_twd2      (o_twd2),
        .o_coeff_addr(o_coeff_addr),
        .o_enable    (o_enable),
        .o_frame_done(o_frame_done),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [127:0] w_twd1, w_s2, w_bfii, w_twd2, w_en, w_fd, w_busy, w_err;
    logic [3:0]   w_addr [128];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int a, input int b);
        logic [127:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle t of the capture sees outputs produced by the edge that opened it.
    task automatic run(input logic [127:0] v_valid, input logic [127:0] v_clr,
                       input logic [127:0] v_rstn, input int ncyc);
        rst = 1'b0;
        i_valid = 1'b0;
        i_clr_err = 1'b0;
        tick();
        tick();
        w_twd1 = '0; w_s2 = '0; w_bfii = '0; w_twd2 = '0;
        w_en = '0; w_fd = '0; w_busy = '0; w_err = '0;
        for (int t = 0; t < ncyc; t++) begin
            tick();
            rst       = v_rstn[t];
            i_valid   = v_valid[t];
            i_clr_err = v_clr[t];
            w_twd1[t] = o_twd1;
            w_s2[t]   = o_stage2_en;
            w_bfii[t] = o_ctrl_bfii;
            w_twd2[t] = o_twd2;
            w_en[t]   = o_enable;
            w_fd[t]   = o_frame_done;
            w_busy[t] = o_busy;
            w_err[t]  = o_err;
            w_addr[t] = o_coeff_addr;
        end
    endtask

    initial begin
        // Reset held with i_valid asserted: everything stays at 0.
        rst = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("reset_outs",
                128'({o_twd1, o_stage2_en, o_ctrl_bfii, o_twd2, o_coeff_addr,
                      o_enable, o_frame_done, o_busy, o_err}), '0);
        end

        // Single frame: 16 beats from cycle 10.
        run(rng(T0, T0 + 15), '0, ~128'b0, 80);
        chk("s1_twd1",  w_twd1, rng(26, 41) | rng(58, 58));
        chk("s1_s2en",  w_s2,   rng(26, 41));
        chk("s1_twd2",  w_twd2, rng(34, 41));
        chk("s1_bfii",  w_bfii, '0);
        chk("s1_en",    w_en,   rng(T0 + LATENCY, T0 + LATENCY + 15));
        chk("s1_fdone", w_fd,   rng(58, 58));
        chk("s1_busy",  w_busy, rng(11, T0 + 15 + DRAIN_LEN));
        chk("s1_err",   w_err,  '0);
        chk("s1_addr30", 128'(w_addr[30]), 128'(4));
        chk("s1_addr41", 128'(w_addr[41]), 128'(15));
        chk("s1_addr45", 128'(w_addr[45]), 128'(0));

        // Four back-to-back frames.
        run(rng(10, 73), '0, ~128'b0, 128);
        chk("b4_twd1",  w_twd1, rng(26, 41) | rng(58, 73) | rng(90, 105));
        chk("b4_s2en",  w_s2,   rng(26, 89));
        chk("b4_twd2",  w_twd2, rng(34, 41) | rng(50, 57) | rng(66, 73) | rng(82, 89));
        chk("b4_bfii",  w_bfii, rng(42, 57) | rng(74, 89));
        chk("b4_en",    w_en,   rng(43, 106));
        chk("b4_fdone", w_fd,   rng(58, 58) | rng(74, 74) | rng(90, 90) | rng(106, 106));
        chk("b4_busy",  w_busy, rng(11, 106));
        chk("b4_err",   w_err,  '0);
        chk("b4_addr60", 128'(w_addr[60]), 128'(2));
        chk("b4_addr89", 128'(w_addr[89]), 128'(15));

        // Drop at beat 7 of frame 2, valid during drain, clear collides with set at 44.
        run(rng(10, 47) & ~rng(33, 33), rng(44, 44) | rng(90, 90), ~128'b0, 100);
        chk("er_err",   w_err,  rng(34, 90));
        chk("er_s2en",  w_s2,   rng(26, 57));
        chk("er_twd1",  w_twd1, rng(26, 41) | rng(58, 73));
        chk("er_twd2",  w_twd2, rng(34, 41) | rng(50, 57));
        chk("er_bfii",  w_bfii, rng(42, 57));
        chk("er_en",    w_en,   rng(43, 74));
        chk("er_fdone", w_fd,   rng(58, 58) | rng(74, 74));
        chk("er_busy",  w_busy, rng(11, 74));

        // Reset pulse 20 beats into RUN, then a clean single frame from cycle 50.
        run(rng(10, 45) | rng(50, 65), '0, ~rng(46, 46), 110);
        chk("rr_busy",  w_busy, rng(11, 46) | rng(51, 98));
        chk("rr_s2en",  w_s2,   rng(26, 46) | rng(66, 81));
        chk("rr_twd1",  w_twd1, rng(26, 41) | rng(66, 81) | rng(98, 98));
        chk("rr_twd2",  w_twd2, rng(34, 41) | rng(74, 81));
        chk("rr_en",    w_en,   rng(43, 46) | rng(83, 98));
        chk("rr_fdone", w_fd,   rng(98, 98));
        chk("rr_err",   w_err,  '0);
        chk("rr_addr47", 128'(w_addr[47]), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Central sequencer for the 2-lane pipelined radix-2² FFT core: generates the stage-1 −j rotation select, stage-2 butterfly-block control, stage-2 rotation select, coefficient-memory address/enable and output-valid from a single input-valid stream. It replaces the per-stage free-running counters and enable delay lines with one framed controller that knows frame boundaries, fill, steady-state and drain, and flags malformed input framing.

## Interface
- `N`, 32, FFT points; one frame = N/2 input beats (2 lanes).
- `D1`, 16, stage-1 half-period in beats; also stage-2 block delay. Must equal N/2.
- `D2`, 8, stage-2 rotation half-period in beats. Must equal D1/2.
- `AW`, $clog2(D1), coefficient address width.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (rst=0 resets).
- `i_valid`  in  1  input sample pair present on the FFT lanes this cycle.
- `i_clr_err`  in  1  one-cycle pulse clears `o_err`.
- `o_twd1`  out  1  stage-1 −j rotation select.
- `o_stage2_en`  out  1  stage-2 active (gates stage-2 control and coefficient memories).
- `o_ctrl_bfii`  out  1  stage-2 butterfly-block swap control.
- `o_twd2`  out  1  stage-2 −j rotation select.
- `o_coeff_addr`  out  AW  coefficient-memory read address.
- `o_enable`  out  1  FFT output registers hold valid data.
- `o_frame_done`  out  1  one-cycle pulse on last output beat of a frame.
- `o_busy`  out  1  state ≠ IDLE.
- `o_err`  out  1  sticky framing error.

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: all counters 0, all outputs 0. i_valid=1 → FILL; that beat is beat 0 (c1 increments to 1).
- c1: mod 2·D1 beat counter, increments every cycle outside IDLE. `o_twd1` = (c1 ≥ D1) combinationally from c1.
- FILL: when c1 wraps from D1−1 to D1 for the first time → RUN, `o_stage2_en`=1 from that cycle.
- c2: mod 2·D1 counter, reset to 0 while `o_stage2_en`=0, increments while 1. `o_ctrl_bfii` = c2[AW]; `o_twd2` = c2[AW−1]; `o_coeff_addr` = c2[AW−1:0].
- RUN: i_valid sampled at every frame boundary (c1 wraps to 0 or D1). i_valid=0 at a boundary → DRAIN, latch drain count = 2·D1+1.
- i_valid=0 at a non-boundary beat in FILL/RUN: set `o_err`, continue counting (pipeline is free-running), transition to DRAIN at next boundary.
- i_valid=1 during DRAIN: ignored for sequencing, sets `o_err`.
- DRAIN: counters keep running; drain count decrements; at 0 → IDLE, all outputs to 0 next cycle.
- `o_enable`: registered, = `o_stage2_en` delayed D1+1 cycles (shift register of depth D1+1, cleared in IDLE and on reset).
- `o_frame_done`: pulse when `o_enable`=1 and the delayed c2 equals D1−1 or 2·D1−1.
- `o_err` cleared only by reset or `i_clr_err`; simultaneous set and clear → set wins.

## Timing
- Reset (rst=0 at a clock edge): state IDLE, c1=c2=0, every output 0, delay line cleared; applies mid-frame with no drain.
- First i_valid at cycle T: `o_twd1` rises at T+D1; `o_stage2_en` rises at T+D1; `o_twd2` rises T+D1+D2; `o_ctrl_bfii` rises T+2·D1; `o_enable` rises T+2·D1+1.
- Steady state: `o_twd1` and `o_ctrl_bfii` period 2·D1, 50 % duty; `o_twd2` period 2·D2.
- Last frame input beat at L (boundary drop seen at L+1): `o_enable` falls at L+2·D1+2, `o_busy` falls the same cycle.
- Back-to-back frames: no gap cycles; `o_enable` stays high continuously.

## Structure
- Package `fft_ctrl_pkg`: state enum, default N/D1/D2, localparam for drain length (2·D1+1) and latency (2·D1+1).
- One sub-module: `fft_en_delay` (parameterised-depth 1-bit shift register with sync clear) for the `o_enable` path; replaces existing enable delay instances.

## Test plan
- Reset: hold rst=0 5 cycles with i_valid=1 → all outputs 0, `o_busy`=0.
- Single frame (16 valid beats from T=10) → `o_stage2_en` at 26, `o_enable` 43..58 high, `o_frame_done` at 58, `o_busy` low at 59.
- 4 back-to-back frames → `o_twd1` toggles every 16, `o_twd2` every 8, `o_enable` continuous 64 cycles, 4 `o_frame_done` pulses 16 apart.
- i_valid drop at beat 7 of frame 2 → `o_err`=1 next cycle, DRAIN at beat 16, return to IDLE after 33 cycles; `i_clr_err` then clears.
- Reset asserted at beat 20 of RUN → next cycle all outputs 0, restart with i_valid yields identical timing to single-frame case.
- `i_clr_err` and error condition same cycle → `o_err` remains 1.
